// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial link endpoints.
// The serializer and the deserializer both import this package. This keeps the
// bit-counter width derivation the same on both ends of the wire.
package deserializer_pkg;

  // Receive FSM encoding: idle line, or a word partially shifted in
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_t;

  // Ceiling log2, usable in parameter defaults
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/deser_out_stage.sv
// One-entry holding register that presents received words to the consumer.
// A word that completes while an unconsumed word is still held and not being
// taken is dropped, and overrun pulses for one cycle. A completion on the same
// edge as a handshake replaces the word, so data_valid stays high.
module deser_out_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_space;

  assign w_space = !r_valid || i_ready;

  // Load, hold, drop or release the held word; overrun marks a dropped completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load) begin
        if (w_space) begin
          r_data  <= i_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/deserializer.sv
// Receive side of the single-wire serial link: shifts in DATA_WIDTH bits, LSB
// first, one per clock while serial_valid is high, and hands each finished word
// to the deser_out_stage holding register.
// Optional feature macro: DESERIALIZER_FRAME_CHECK_EN adds the sticky
// frame_error output (short frames, and a low line while idle).
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNTER_SIZE = clog2(DATA_WIDTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  overrun
`ifdef DESERIALIZER_FRAME_CHECK_EN
  ,
  output logic                  frame_error
`endif
);

  deser_state_t          r_state;
  deser_state_t          w_next_state;
  logic [COUNTER_SIZE-1:0] r_count;
  logic [COUNTER_SIZE-1:0] w_next_count;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic [DATA_WIDTH-1:0]   w_next_shreg;
  logic [DATA_WIDTH-1:0]   w_word;
  logic                    w_complete;

  // The incoming bit enters at the top, so after DATA_WIDTH shifts bit 0 is the first bit
  assign w_word = {serial_in, r_shreg[DATA_WIDTH-1:1]};

  // State, bit counter and shift register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_shreg <= w_next_shreg;
    end
  end

  // Next-state logic: sample while serial_valid is high, finish on bit DATA_WIDTH, drop short frames
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_shreg = r_shreg;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (serial_valid) begin
          w_next_state = ST_SHIFT;
          w_next_count = COUNTER_SIZE'(1);
          w_next_shreg = w_word;
        end
      end
      ST_SHIFT: begin
        if (serial_valid) begin
          w_next_shreg = w_word;
          if (r_count == COUNTER_SIZE'(DATA_WIDTH - 1)) begin
            w_complete   = 1'b1;
            w_next_count = '0;
            w_next_state = ST_IDLE;
          end else begin
            w_next_count = r_count + COUNTER_SIZE'(1);
          end
        end else begin
          w_next_state = ST_IDLE;
          w_next_count = '0;
          w_next_shreg = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_count = '0;
        w_next_shreg = '0;
      end
    endcase
  end

  assign busy = (r_state == ST_SHIFT);

  deser_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_complete),
    .i_word    (w_word),
    .i_ready   (data_ready),
    .o_data    (data_out),
    .o_valid   (data_valid),
    .o_overrun (overrun)
  );

`ifdef DESERIALIZER_FRAME_CHECK_EN
  logic r_frame_error;

  // Sticky flag: a frame ended early, or the line was low while no frame was in progress
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_error <= 1'b0;
    end else if (!serial_valid && ((r_state == ST_SHIFT) || !serial_in)) begin
      r_frame_error <= 1'b1;
    end
  end

  assign frame_error = r_frame_error;
`endif

endmodule
